// File: rtl/minibus_arbiter.sv
// Two-master round-robin arbiter onto a single shared slave bus.
// Transfers are bounded by a wait-cycle timeout; a simultaneous read+write request is rejected with err.
//
// state | meaning
// IDLE  | no grant; sample master requests and pick an owner
// BUSY  | owner's request forwarded to the slave; waiting for s_ready or timeout
// DONE  | one-cycle gap with no grant after a completed or aborted transfer
module minibus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_ren,
  input  logic              m0_wen,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_ren,
  input  logic              m1_wen,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_ren,
  output logic              s_wen,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req0, req1;
  logic        done_c, err_c;

  assign req0 = m0_ren | m0_wen;
  assign req1 = m1_ren | m1_wen;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      illegal_q    <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      illegal_q    <= illegal_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    illegal_d    = illegal_q;
    cnt_d        = cnt_q;
    done_c       = 1'b0;
    err_c        = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_ren        = 1'b0;
    s_wen        = 1'b0;
    m0_rdata     = '0;
    m0_ready     = 1'b0;
    m0_err       = 1'b0;
    m1_rdata     = '0;
    m1_ready     = 1'b0;
    m1_err       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d   = (req0 && req1) ? ~last_grant_q : req1;
          // Read+write together is judged once, at grant, so later request changes cannot revive it.
          illegal_d = owner_d ? (m1_ren & m1_wen) : (m0_ren & m0_wen);
          cnt_d     = 8'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (illegal_q) begin
          done_c = 1'b1;
          err_c  = 1'b1;
        end else begin
          s_addr  = owner_q ? m1_addr  : m0_addr;
          s_wdata = owner_q ? m1_wdata : m0_wdata;
          s_ren   = owner_q ? m1_ren   : m0_ren;
          s_wen   = owner_q ? m1_wen   : m0_wen;
          if (s_ready) begin
            done_c = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            done_c = 1'b1;
            err_c  = 1'b1;
            s_ren  = 1'b0;
            s_wen  = 1'b0;
          end
        end
        if (done_c) begin
          state_d      = DONE;
          last_grant_d = owner_q;
          if (owner_q) begin
            m1_ready = 1'b1;
            m1_err   = err_c;
            m1_rdata = err_c ? '0 : s_rdata;
          end else begin
            m0_ready = 1'b1;
            m0_err   = err_c;
            m0_rdata = err_c ? '0 : s_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Directed bench for minibus_arbiter: single read, alternating ties, timeout,
// illegal read+write, reset mid-transfer and spurious slave ready.
module tb_minibus_arbiter;

  logic        clk;
  logic        nrst;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ren, m0_wen, m0_ready, m0_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ren, m1_wen, m1_ready, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ren, s_wen, s_ready;

  int checks = 0;
  int errors = 0;

  minibus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .nrst(nrst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ren(m0_ren), .m0_wen(m0_wen),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ren(m1_ren), .m1_wen(m1_wen),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ren(s_ren), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    m0_ren = 1'b0; m0_wen = 1'b0;
    m1_ren = 1'b0; m1_wen = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_m0_ready"}, 64'(m0_ready), 64'd0);
    check_eq({tag, "_m1_ready"}, 64'(m1_ready), 64'd0);
    check_eq({tag, "_m0_err"},   64'(m0_err),   64'd0);
    check_eq({tag, "_m1_err"},   64'(m1_err),   64'd0);
    check_eq({tag, "_s_ren"},    64'(s_ren),    64'd0);
    check_eq({tag, "_s_wen"},    64'(s_wen),    64'd0);
    check_eq({tag, "_s_addr"},   64'(s_addr),   64'd0);
    check_eq({tag, "_m0_rdata"}, 64'(m0_rdata), 64'd0);
  endtask

  initial begin
    nrst = 1'b0;
    drop_reqs();
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_ready = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // single m0 read, slave ready on first BUSY cycle
    m0_addr = 32'h10; m0_ren = 1'b1;
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    check_eq("rd_idle_m0_ready", 64'(m0_ready), 64'd0);
    check_eq("rd_idle_s_ren",    64'(s_ren),    64'd0);
    tick();
    check_eq("rd_m0_ready", 64'(m0_ready), 64'd1);
    check_eq("rd_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    check_eq("rd_m0_err",   64'(m0_err),   64'd0);
    check_eq("rd_m1_ready", 64'(m1_ready), 64'd0);
    check_eq("rd_s_ren",    64'(s_ren),    64'd1);
    check_eq("rd_s_addr",   64'(s_addr),   64'h10);
    tick();
    drop_reqs();
    check_eq("rd_done_m0_ready", 64'(m0_ready), 64'd0);
    check_eq("rd_done_s_ren",    64'(s_ren),    64'd0);
    tick();

    // continuous ties from reset: m0, m1, m0, m1 at cycles 1, 4, 7, 10
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    m0_addr = 32'h100; m1_addr = 32'h200;
    m0_ren = 1'b1; m1_ren = 1'b1; s_rdata = 32'h55;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_eq($sformatf("rr_m0_ready_%0d", k), 64'(m0_ready), 64'(k == 1 || k == 7));
      check_eq($sformatf("rr_m1_ready_%0d", k), 64'(m1_ready), 64'(k == 4 || k == 10));
      if (k == 4) check_eq("rr_s_addr_m1", 64'(s_addr), 64'h200);
      if (k == 7) check_eq("rr_s_addr_m0", 64'(s_addr), 64'h100);
      tick();
    end
    drop_reqs();
    tick();

    // m1 write, slave never ready: err on 16th BUSY cycle
    s_ready = 1'b0; s_rdata = 32'h1234;
    m1_addr = 32'h4000; m1_wdata = 32'h5; m1_wen = 1'b1;
    tick();
    check_eq("to_s_addr",  64'(s_addr),  64'h4000);
    check_eq("to_s_wdata", 64'(s_wdata), 64'h5);
    for (int i = 1; i <= 16; i++) begin
      check_eq($sformatf("to_s_wen_%0d", i),    64'(s_wen),    64'(i < 16));
      check_eq($sformatf("to_m1_ready_%0d", i), 64'(m1_ready), 64'(i == 16));
      check_eq($sformatf("to_m1_err_%0d", i),   64'(m1_err),   64'(i == 16));
      check_eq($sformatf("to_m0_ready_%0d", i), 64'(m0_ready), 64'd0);
      if (i == 16) check_eq("to_m1_rdata", 64'(m1_rdata), 64'd0);
      tick();
    end
    check_eq("to_done_s_wen",    64'(s_wen),    64'd0);
    check_eq("to_done_m1_ready", 64'(m1_ready), 64'd0);
    drop_reqs();
    tick();

    // m0 read and write together: rejected without touching the slave
    m0_ren = 1'b1; m0_wen = 1'b1; s_ready = 1'b1;
    #1;
    check_eq("ill_idle_s_ren", 64'(s_ren), 64'd0);
    tick();
    check_eq("ill_m0_ready", 64'(m0_ready), 64'd1);
    check_eq("ill_m0_err",   64'(m0_err),   64'd1);
    check_eq("ill_s_ren",    64'(s_ren),    64'd0);
    check_eq("ill_s_wen",    64'(s_wen),    64'd0);
    check_eq("ill_m1_ready", 64'(m1_ready), 64'd0);
    tick();
    check_eq("ill_done_s_ren",    64'(s_ren),    64'd0);
    check_eq("ill_done_m0_ready", 64'(m0_ready), 64'd0);
    drop_reqs();
    tick();

    // reset mid-BUSY, then a tie must go to m0
    s_ready = 1'b0; m0_addr = 32'h44; m0_ren = 1'b1;
    tick();
    check_eq("rst_busy_s_ren", 64'(s_ren), 64'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #2;
    nrst = 1'b1;
    m1_ren = 1'b1; s_ready = 1'b1; s_rdata = 32'h77;
    tick();
    check_eq("rst_tie_m0_ready", 64'(m0_ready), 64'd1);
    check_eq("rst_tie_m1_ready", 64'(m1_ready), 64'd0);
    check_eq("rst_tie_m0_rdata", 64'(m0_rdata), 64'h77);
    tick();
    drop_reqs();
    tick();

    // spurious s_ready while idle
    s_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq($sformatf("spur_m0_ready_%0d", j), 64'(m0_ready), 64'd0);
      check_eq($sformatf("spur_m1_ready_%0d", j), 64'(m1_ready), 64'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
